perf_counter_bank: RTL

Parametrised performance-counter bank for the pipelined CPU/cache experiments. It replaces the fixed 8-bit clock/instruction/hit counters on the top level with:
- a cycle counter plus `NUM_EVT` event counters;
- selectable wrap or saturate behaviour, with sticky overflow flags;
- a synchronous clear and a snapshot register file read through a select port.

It sits beside the core. The core drives one event strobe per counted event, for example instruction retired, cache hit and cache miss.

---
 rtl/perf_counter_bank.sv | 107 ++++++++++
 1 files changed

// File: rtl/perf_counter_bank.sv
// Performance counter bank: a free-running cycle counter (ch0) plus NUM_EVT event counters.
// Live counters wrap or saturate, and each channel has a sticky overflow flag and a snapshot copy.
module perf_cnt_lane #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  input  logic             i_snap,
  output logic [WIDTH-1:0] o_cnt,
  output logic [WIDTH-1:0] o_snap,
  output logic             o_ovf
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt, r_snap;
  logic             r_ovf;
  logic             w_top;

  assign w_top = &r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_snap <= '0;
      r_ovf  <= 1'b0;
    end else begin
      // The snapshot takes the pre-edge value, so it sees neither this cycle's increment nor the clear.
      if (i_snap) r_snap <= r_cnt;
      if (i_clr) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (i_inc) begin
        if (w_top) begin
          r_ovf <= 1'b1;
          if (!SATURATE) r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + ONE;
        end
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_snap = r_snap;
  assign o_ovf  = r_ovf;
endmodule

module perf_counter_bank #(
  parameter int WIDTH    = 8,
  parameter int NUM_EVT  = 3,
  parameter bit SATURATE = 1'b0,
  parameter int SEL_W    = $clog2(NUM_EVT + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           clr,
  input  logic [NUM_EVT-1:0]             evt,
  input  logic                           snap,
  input  logic [SEL_W-1:0]               rd_sel,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           snap_valid,
  output logic [(NUM_EVT+1)*WIDTH-1:0]   cnt_live,
  output logic [NUM_EVT:0]               ovf
);
  localparam int RD_N = 1 << SEL_W;

  logic [NUM_EVT:0]            w_inc;
  logic [NUM_EVT:0][WIDTH-1:0] w_cnt, w_snap;
  logic [RD_N-1:0][WIDTH-1:0]  w_rd_tab;
  logic                        r_snap_vld;

  assign w_inc = en ? {evt, 1'b1} : '0;

  perf_cnt_lane #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_lane [NUM_EVT:0] (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_inc),
    .i_clr  (clr),
    .i_snap (snap),
    .o_cnt  (w_cnt),
    .o_snap (w_snap),
    .o_ovf  (ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_snap_vld <= 1'b0;
    else if (snap) r_snap_vld <= 1'b1;
    else if (clr)  r_snap_vld <= 1'b0;
  end

  // Pad the read table to the full select range so unused codes read as zero.
  for (genvar k = 0; k < RD_N; k++) begin : g_rd
    if (k <= NUM_EVT) begin : g_ch
      assign w_rd_tab[k] = w_snap[k];
    end else begin : g_pad
      assign w_rd_tab[k] = '0;
    end
  end

  assign rd_data    = w_rd_tab[rd_sel];
  assign snap_valid = r_snap_vld;
  assign cnt_live   = w_cnt;
endmodule
